// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction-fetch stage and its queue.
package cpu_pkg;

    localparam int          INST_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;  // sll $0,$0,0

    // One fetched word together with the address it was fetched from
    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; the low two bits are dropped
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Control, instruction-memory and IF/ID-facing signals of the fetch stage.
interface if_fetch_stage_if;
    import cpu_pkg::*;

    logic              stall;
    logic              redirect_valid;
    logic [INST_W-1:0] redirect_pc;
    logic              imem_en;
    logic [INST_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic [INST_W-1:0] out_PC;
    logic [INST_W-1:0] out_Instruction;
    logic              out_valid;

    // Fetch stage side
    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_en, imem_addr, out_PC, out_Instruction, out_valid
    );

    // Pipeline control, ROM and IF/ID side
    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_en, imem_addr, out_PC, out_Instruction, out_valid
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of fetched words. No fall-through: a pushed
// word becomes visible at the head one cycle later.
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // Next-state: flush/reset empty the queue, otherwise push and pop may coincide
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        if (rst || flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the fetch PC, drives a 1-cycle-latency
// instruction ROM, and buffers responses so IF/ID stalls lose no words.
// Redirects flush everything in flight and refetch from the target.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST,
    parameter int          FQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_stage_if.master  bus
);
    import cpu_pkg::*;

    // The occupancy arithmetic below assumes exactly two queue slots
    generate
        if (FQ_DEPTH != 2) begin : g_bad_depth
            $error("if_fetch_stage: FQ_DEPTH must be 2");
        end
    endgenerate

    logic [31:0]  fpc_q, fpc_d;
    logic [31:0]  rpc_q, rpc_d;
    logic         rvalid_q, rvalid_d;
    logic [1:0]   fq_count;
    fetch_entry_t fq_head;
    fetch_entry_t head;
    fetch_entry_t resp;
    logic         head_valid;
    logic         pop;
    logic         fq_pop;
    logic         push;
    logic         issue;
    logic [2:0]   occupancy;

    // Head selection, consume/capture decisions, ROM issue and presented outputs
    always_comb begin
        resp       = '{pc: rpc_q, inst: bus.imem_rdata};
        head_valid = (fq_count != 2'd0) || rvalid_q;
        if (fq_count != 2'd0) begin
            head = fq_head;
        end else begin
            head = resp;  // fall-through of the response arriving this cycle
        end
        pop       = !bus.stall && head_valid && !bus.redirect_valid;
        fq_pop    = pop && (fq_count != 2'd0);
        push      = rvalid_q && !((fq_count == 2'd0) && pop);
        occupancy = {1'b0, fq_count} + {2'b00, rvalid_q} - {2'b00, pop};
        issue     = (occupancy < 3'd2) && !bus.redirect_valid && !rst;

        bus.imem_en   = issue;
        bus.imem_addr = fpc_q;
        bus.out_valid = head_valid && !bus.redirect_valid;
        if (bus.out_valid) begin
            bus.out_Instruction = head.inst;
            bus.out_PC          = head.pc + 32'd4;
        end else begin
            bus.out_Instruction = NOP_INST;
            bus.out_PC          = 32'h0000_0000;
        end
    end

    // Fetch PC / in-flight response tracking: reset, then redirect, then issue
    always_comb begin
        fpc_d    = fpc_q;
        rpc_d    = rpc_q;
        rvalid_d = 1'b0;
        if (rst) begin
            fpc_d = RESET_PC;
        end else if (bus.redirect_valid) begin
            fpc_d = word_align(bus.redirect_pc);
        end else if (issue) begin
            rpc_d    = fpc_q;
            rvalid_d = 1'b1;
            fpc_d    = fpc_q + 32'd4;  // wraps modulo 2^32
        end else begin
            fpc_d = fpc_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        fpc_q    <= fpc_d;
        rpc_q    <= rpc_d;
        rvalid_q <= rvalid_d;
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_data (resp),
        .pop       (fq_pop),
        .count     (fq_count),
        .head      (fq_head)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal
// expectations plus a per-cycle comparison against a word-count model.
module tb_if_fetch_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM: mem[a] = 0xA000_0000 | a, one cycle read latency
    initial bus.imem_rdata = 32'h0;
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= 32'hA000_0000 | bus.imem_addr;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: since the last reset/redirect, words are fetched from base in
    // order. 'iss' counts ROM reads issued, 'con' counts words consumed.
    // A word is presentable while iss > con; at most two may be outstanding.
    logic [31:0] m_base = 32'h0;
    logic [31:0] m_iss  = 32'h0;
    logic [31:0] m_con  = 32'h0;
    logic [31:0] m_pc;
    logic        m_valid, m_pop, m_en;
    bit          m_on   = 1'b0;

    always @(negedge clk) begin
        m_valid = 1'b0;
        m_pop   = 1'b0;
        m_en    = 1'b0;
        if (m_on) begin
            if (rst) begin
                chk("rst_imem_en", {31'b0, bus.imem_en}, 32'd0);
            end else begin
                m_valid = (m_iss != m_con) && !bus.redirect_valid;
                m_pc    = m_base + (m_con << 2);
                m_pop   = m_valid && !bus.stall;
                m_en    = !bus.redirect_valid && ((m_iss - m_con - {31'b0, m_pop}) < 32'd2);
                chk("m_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
                chk("m_inst", bus.out_Instruction, m_valid ? (32'hA000_0000 | m_pc) : NOP_INST);
                chk("m_pc", bus.out_PC, m_valid ? (m_pc + 32'd4) : 32'h0);
                chk("m_imem_en", {31'b0, bus.imem_en}, {31'b0, m_en});
                if (m_en) chk("m_imem_addr", bus.imem_addr, m_base + (m_iss << 2));
            end
        end
        if (rst) begin
            m_base = RESET_PC;
            m_iss  = 32'h0;
            m_con  = 32'h0;
            m_on   = 1'b1;
        end else if (bus.redirect_valid) begin
            m_base = bus.redirect_pc & 32'hFFFF_FFFC;
            m_iss  = 32'h0;
            m_con  = 32'h0;
        end else if (m_on) begin
            m_iss = m_iss + {31'b0, m_en};
            m_con = m_con + {31'b0, m_pop};
        end
    end

    // Drive inputs for the cycle starting at the next posedge
    task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rp);
        @(posedge clk);
        #1;
        rst                = r;
        bus.stall          = s;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
    endtask

    // Sample point for literal checks: late in the current cycle
    task automatic settle();
        #3;
    endtask

    logic [63:0] stall_pat;

    initial begin
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        stall_pat          = 64'hF0C3_9A5E_1234_8765;

        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);

        // Reset release, free running
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("A0_en", {31'b0, bus.imem_en}, 32'd1);
        chk("A0_addr", bus.imem_addr, 32'h0);
        chk("A0_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("A0_inst", bus.out_Instruction, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("A1_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("A1_inst", bus.out_Instruction, 32'hA000_0000);
        chk("A1_pc", bus.out_PC, 32'h4);
        chk("A1_addr", bus.imem_addr, 32'h4);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("A2_inst", bus.out_Instruction, 32'hA000_0004);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Stall cycles 1-3 after a fresh reset
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0); settle();
        chk("B1_inst", bus.out_Instruction, 32'hA000_0000);
        cyc(1'b0, 1'b1, 1'b0, 32'h0); settle();
        chk("B2_inst", bus.out_Instruction, 32'hA000_0000);
        chk("B2_en", {31'b0, bus.imem_en}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0); settle();
        chk("B3_inst", bus.out_Instruction, 32'hA000_0000);
        chk("B3_en", {31'b0, bus.imem_en}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("B4_inst", bus.out_Instruction, 32'hA000_0000);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("B5_inst", bus.out_Instruction, 32'hA000_0004);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("B6_inst", bus.out_Instruction, 32'hA000_0008);

        // Redirect to an unaligned target
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0103); settle();
        chk("C0_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("C0_inst", bus.out_Instruction, NOP_INST);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("C1_addr", bus.imem_addr, 32'h100);
        chk("C1_en", {31'b0, bus.imem_en}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("C2_inst", bus.out_Instruction, 32'hA000_0100);
        chk("C2_pc", bus.out_PC, 32'h104);

        // Redirect while stalled with a full queue
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 32'h200);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0); settle();
            chk("D_hold_inst", bus.out_Instruction, 32'hA000_0200);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("D_rel_inst", bus.out_Instruction, 32'hA000_0200);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("D_next_inst", bus.out_Instruction, 32'hA000_0204);

        // Reset pulse with a full queue
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0); settle();
        chk("E_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("E_en", {31'b0, bus.imem_en}, 32'd1);
        chk("E_addr", bus.imem_addr, RESET_PC);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect to the top of the address space: fetch wraps to 0
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("F0_inst", bus.out_Instruction, 32'hFFFF_FFFC);
        chk("F0_pc", bus.out_PC, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("F1_inst", bus.out_Instruction, 32'hA000_0000);
        chk("F1_pc", bus.out_PC, 32'h4);

        // Back-to-back redirects: the last one wins
        cyc(1'b0, 1'b0, 1'b1, 32'h300);
        cyc(1'b0, 1'b0, 1'b1, 32'h400);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); settle();
        chk("G_inst", bus.out_Instruction, 32'hA000_0400);
        chk("G_pc", bus.out_PC, 32'h404);

        // Mixed stall pattern with occasional redirects and one reset
        for (int i = 0; i < 128; i++) begin
            cyc((i == 90) ? 1'b1 : 1'b0,
                stall_pat[i % 64],
                ((i % 37) == 20) ? 1'b1 : 1'b0,
                32'h0000_1000 + 32'(i * 8));
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 32'h0);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
